// File: rtl/dmem_core_arbiter_pkg.sv
// Shared definitions for the data-memory port arbiter: FSM encoding and AMO funct5 masks.
package dmem_core_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT    = 2'd2,
        RELEASE = 2'd3
    } arb_state_t;

    // Compared against funct5[1:0] of the granted request
    localparam logic [1:0] LR_T = 2'b10;
    localparam logic [1:0] SC_T = 2'b11;

    function automatic logic amo_match(input logic is_amo, input logic [4:0] amo_type,
                                       input logic [1:0] mask);
        return is_amo && (amo_type[1:0] == mask);
    endfunction

endpackage

// File: rtl/dmem_core_arbiter_rr_pick.sv
// Round-robin winner search: starts one past the last granted index and wraps modulo N.
module dmem_core_arbiter_rr_pick #(
    parameter int N  = 2,
    parameter int IW = 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] winner,
    output logic          valid
);

    // Walk from the farthest candidate to the nearest so the nearest one is written last
    always_comb begin
        int c;
        valid  = 1'b0;
        winner = '0;
        c      = 0;
        for (int i = N; i >= 1; i--) begin
            c = (int'(ptr) + i) % N;
            if (req[c]) begin
                valid  = 1'b1;
                winner = IW'(c);
            end
        end
    end

endmodule

// File: rtl/dmem_core_arbiter.sv
// N-core arbiter for the atomic-unit data-memory port; optional LR/SC lock under ARB_LR_LOCK_EN.
//
// state   | meaning
// IDLE    | no grant held; arbitrate among requesters
// ISSUE   | one-cycle issue pulse to the atomic unit
// WAIT    | grant held until core_done_i
// RELEASE | dead cycle so the requester can drop its strobe
module dmem_core_arbiter
    import dmem_core_arbiter_pkg::*;
#(
    parameter int N           = 2,
    parameter int XLEN        = 32,
    parameter int CBSIZE      = 256,
    parameter int LOCK_CYCLES = 64
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [N-1:0]        P_strobe_i,
    input  logic [N*XLEN-1:0]   P_addr_i,
    input  logic [N-1:0]        P_rw_i,
    input  logic [N*CBSIZE-1:0] P_data_i,
    input  logic [N-1:0]        P_is_amo_i,
    input  logic [N*5-1:0]      P_amo_type_i,
    output logic [N-1:0]        P_done_o,
    output logic [CBSIZE-1:0]   P_data_o,
    output logic [N-1:0]        core_id_o,
    output logic                core_strobe_o,
    output logic [XLEN-1:0]     core_addr_o,
    output logic                core_rw_o,
    output logic [CBSIZE-1:0]   core_data_o,
    output logic                core_is_amo_o,
    output logic [4:0]          core_amo_type_o,
    input  logic                core_done_i,
    input  logic [CBSIZE-1:0]   core_data_i
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [N-1:0] ID_ONE = N'(1);

    arb_state_t    state;
    logic [IW-1:0] grant;
    logic [IW-1:0] ptr;
    logic [IW-1:0] pick_idx;
    logic          pick_valid;
    logic [N-1:0]  req_eff;
    logic          lock_live;
    logic          busy;
    logic          done_xfer;

    assign busy      = (state == ISSUE) || (state == WAIT);
    assign done_xfer = busy && core_done_i;

    assign P_done_o = done_xfer ? core_id_o : '0;
    assign P_data_o = rst_ni ? core_data_i : '0;

    dmem_core_arbiter_rr_pick #(
        .N  (N),
        .IW (IW)
    ) u_rr_pick (
        .req    (req_eff),
        .ptr    (ptr),
        .winner (pick_idx),
        .valid  (pick_valid)
    );

`ifdef ARB_LR_LOCK_EN
    localparam int CW = $clog2(LOCK_CYCLES + 1);

    logic          locked;
    logic [IW-1:0] lock_core;
    logic [CW-1:0] lock_cnt;

    // The lock lapses in the same cycle the counter reaches the limit
    assign lock_live = locked && (lock_cnt != CW'(LOCK_CYCLES));
    assign req_eff   = lock_live ? (P_strobe_i & (ID_ONE << lock_core)) : P_strobe_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            locked    <= 1'b0;
            lock_core <= '0;
            lock_cnt  <= '0;
        end else if (done_xfer && amo_match(core_is_amo_o, core_amo_type_o, LR_T)) begin
            locked    <= 1'b1;
            lock_core <= grant;
            lock_cnt  <= '0;
        end else if (locked && (!lock_live ||
                     (done_xfer && (grant == lock_core) &&
                      amo_match(core_is_amo_o, core_amo_type_o, SC_T)))) begin
            locked   <= 1'b0;
            lock_cnt <= '0;
        end else if (locked) begin
            lock_cnt <= lock_cnt + 1'b1;
        end
    end
`else
    logic unused_lock_cfg;

    assign lock_live       = 1'b0;
    assign req_eff         = P_strobe_i;
    assign unused_lock_cfg = (LOCK_CYCLES > 0);
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state           <= IDLE;
            grant           <= '0;
            ptr             <= IW'(N - 1);
            core_id_o       <= '0;
            core_strobe_o   <= 1'b0;
            core_addr_o     <= '0;
            core_rw_o       <= 1'b0;
            core_data_o     <= '0;
            core_is_amo_o   <= 1'b0;
            core_amo_type_o <= '0;
        end else begin
            core_strobe_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        // Fields are captured here so a requester changing them mid-flight has no effect
                        grant           <= pick_idx;
                        core_id_o       <= ID_ONE << pick_idx;
                        core_strobe_o   <= 1'b1;
                        core_addr_o     <= P_addr_i[int'(pick_idx)*XLEN +: XLEN];
                        core_rw_o       <= P_rw_i[pick_idx];
                        core_data_o     <= P_data_i[int'(pick_idx)*CBSIZE +: CBSIZE];
                        core_is_amo_o   <= P_is_amo_i[pick_idx];
                        core_amo_type_o <= P_amo_type_i[int'(pick_idx)*5 +: 5];
                        if (!lock_live) begin
                            ptr <= pick_idx;
                        end
                        state <= ISSUE;
                    end
                end
                ISSUE, WAIT: begin
                    if (core_done_i) begin
                        core_id_o       <= '0;
                        core_addr_o     <= '0;
                        core_rw_o       <= 1'b0;
                        core_data_o     <= '0;
                        core_is_amo_o   <= 1'b0;
                        core_amo_type_o <= '0;
                        state           <= RELEASE;
                    end else begin
                        state <= WAIT;
                    end
                end
                RELEASE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_core_arbiter.sv
// Self-checking bench for dmem_core_arbiter: vector table, grant scoreboard, hand-written corner sequences.
module tb_dmem_core_arbiter;

    localparam int N           = 2;
    localparam int XLEN        = 32;
    localparam int CBSIZE      = 256;
    localparam int LOCK_CYCLES = 64;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [N-1:0]        P_strobe_i = '0;
    logic [N*XLEN-1:0]   P_addr_i = '0;
    logic [N-1:0]        P_rw_i = '0;
    logic [N*CBSIZE-1:0] P_data_i = '0;
    logic [N-1:0]        P_is_amo_i = '0;
    logic [N*5-1:0]      P_amo_type_i = '0;
    logic [N-1:0]        P_done_o;
    logic [CBSIZE-1:0]   P_data_o;
    logic [N-1:0]        core_id_o;
    logic                core_strobe_o;
    logic [XLEN-1:0]     core_addr_o;
    logic                core_rw_o;
    logic [CBSIZE-1:0]   core_data_o;
    logic                core_is_amo_o;
    logic [4:0]          core_amo_type_o;
    logic                core_done_i = 1'b0;
    logic [CBSIZE-1:0]   core_data_i = '0;

    int nchk = 0;
    int nerr = 0;
    int cyc  = 0;

    dmem_core_arbiter #(
        .N(N), .XLEN(XLEN), .CBSIZE(CBSIZE), .LOCK_CYCLES(LOCK_CYCLES)
    ) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .P_strobe_i      (P_strobe_i),
        .P_addr_i        (P_addr_i),
        .P_rw_i          (P_rw_i),
        .P_data_i        (P_data_i),
        .P_is_amo_i      (P_is_amo_i),
        .P_amo_type_i    (P_amo_type_i),
        .P_done_o        (P_done_o),
        .P_data_o        (P_data_o),
        .core_id_o       (core_id_o),
        .core_strobe_o   (core_strobe_o),
        .core_addr_o     (core_addr_o),
        .core_rw_o       (core_rw_o),
        .core_data_o     (core_data_o),
        .core_is_amo_o   (core_is_amo_o),
        .core_amo_type_o (core_amo_type_o),
        .core_done_i     (core_done_i),
        .core_data_i     (core_data_i)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [N-1:0]      id;
        logic [XLEN-1:0]   addr;
        logic              rw;
        logic [CBSIZE-1:0] data;
        logic              amo;
        logic [4:0]        ty;
    } sb_t;

    sb_t sb[$];
    sb_t sb_e;

    typedef struct {
        int          core;
        logic [31:0] addr;
        logic [31:0] addr2;
        logic        rw;
        logic        amo;
        logic [4:0]  ty;
        int          lat;
        logic        drop;
        logic [31:0] rseed;
        logic [N-1:0] exp_id;
        int          exp_lat;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && core_strobe_o) begin
            if (sb.size() == 0) begin
                nchk++;
                nerr++;
                $display("FAIL sb_unexpected: core_strobe_o with id %b, none expected", core_id_o);
            end else begin
                sb_e = sb.pop_front();
                check("sb_id", core_id_o, sb_e.id);
                check("sb_addr", core_addr_o, sb_e.addr);
                check("sb_rw", core_rw_o, sb_e.rw);
                check("sb_data", core_data_o, sb_e.data);
                check("sb_amo", core_is_amo_o, sb_e.amo);
                check("sb_type", core_amo_type_o, sb_e.ty);
            end
        end
    end

    task automatic set_req(input int c, input logic [31:0] a, input logic rw,
                           input logic amo, input logic [4:0] ty);
        P_strobe_i[c] = 1'b1;
        P_addr_i[c*XLEN +: XLEN] = a;
        P_rw_i[c] = rw;
        P_data_i[c*CBSIZE +: CBSIZE] = {8{a}};
        P_is_amo_i[c] = amo;
        P_amo_type_i[c*5 +: 5] = ty;
    endtask

    task automatic push_exp(input int c, input logic [31:0] a, input logic rw,
                            input logic amo, input logic [4:0] ty);
        sb_t e;
        e.id   = N'(1) << c;
        e.addr = a;
        e.rw   = rw;
        e.data = {8{a}};
        e.amo  = amo;
        e.ty   = ty;
        sb.push_back(e);
    endtask

    task automatic wait_issue(input int bound, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!core_strobe_o && n < bound);
        nchk++;
        if (!core_strobe_o) begin
            nerr++;
            $display("FAIL issue_timeout: no core_strobe_o after %0d cycles", n);
        end
    endtask

    // Called at the negedge of the ISSUE cycle; returns at the negedge of the following IDLE cycle
    task automatic serve(input int c, input logic [31:0] a, input logic [31:0] a2, input int lat,
                         input logic drop, input logic [CBSIZE-1:0] rd, input logic [N-1:0] exp_id,
                         input string nm);
        check({nm, "_id_issue"}, core_id_o, exp_id);
        if (drop) P_strobe_i[c] = 1'b0;
        for (int k = 0; k < lat; k++) begin
            @(negedge clk);
            if (k == 0) begin
                check({nm, "_strobe_pulse"}, core_strobe_o, 1'b0);
                P_addr_i[c*XLEN +: XLEN] = a2;
            end
        end
        core_done_i = 1'b1;
        core_data_i = rd;
        #1;
        check({nm, "_done_route"}, P_done_o, exp_id);
        check({nm, "_rdata"}, P_data_o, rd);
        check({nm, "_addr_hold"}, core_addr_o, a);
        @(negedge clk);
        core_done_i = 1'b0;
        core_data_i = '0;
        check({nm, "_release_id"}, core_id_o, '0);
        check({nm, "_release_addr"}, core_addr_o, '0);
        P_strobe_i[c] = 1'b0;
        @(negedge clk);
        check({nm, "_idle_id"}, core_id_o, '0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        P_strobe_i = '0;
        core_done_i = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        nerr++;
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int t0;
        int t1;

        vecs[0] = '{0, 32'h0000_1000, 32'h0000_2000, 1'b0, 1'b0, 5'd0, 3, 1'b0, 32'h1111_0000, 2'b01, 1};
        vecs[1] = '{1, 32'h0000_4000, 32'h0000_4000, 1'b1, 1'b0, 5'd0, 0, 1'b0, 32'h2222_0000, 2'b10, 1};
        vecs[2] = '{0, 32'h0000_5008, 32'h0000_5008, 1'b0, 1'b1, 5'b00001, 1, 1'b1, 32'h3333_0000, 2'b01, 1};
        vecs[3] = '{1, 32'hdead_beef, 32'hdead_beef, 1'b0, 1'b0, 5'd0, 2, 1'b0, 32'h4444_0000, 2'b10, 1};
        vecs[4] = '{0, 32'h0000_7ff0, 32'h0000_7ff0, 1'b1, 1'b0, 5'd0, 0, 1'b0, 32'h5555_0000, 2'b01, 1};

        repeat (2) @(negedge clk);
        check("rst_id", core_id_o, '0);
        check("rst_strobe", core_strobe_o, 1'b0);
        check("rst_addr", core_addr_o, '0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            set_req(vecs[i].core, vecs[i].addr, vecs[i].rw, vecs[i].amo, vecs[i].ty);
            push_exp(vecs[i].core, vecs[i].addr, vecs[i].rw, vecs[i].amo, vecs[i].ty);
            wait_issue(20, n);
            check("vec_latency", n, vecs[i].exp_lat);
            serve(vecs[i].core, vecs[i].addr, vecs[i].addr2, vecs[i].lat, vecs[i].drop,
                  {8{vecs[i].rseed}}, vecs[i].exp_id, $sformatf("vec%0d", i));
        end

        // Reset asserted while a transaction sits in WAIT
        set_req(0, 32'h0000_3000, 1'b0, 1'b0, 5'd0);
        push_exp(0, 32'h0000_3000, 1'b0, 1'b0, 5'd0);
        wait_issue(20, n);
        repeat (2) @(negedge clk);
        core_done_i = 1'b1;
        core_data_i = {8{32'hcafe_f00d}};
        rst_n = 1'b0;
        #1;
        check("rstmid_id", core_id_o, '0);
        check("rstmid_strobe", core_strobe_o, 1'b0);
        check("rstmid_done", P_done_o, '0);
        check("rstmid_pdata", P_data_o, '0);
        check("rstmid_addr", core_addr_o, '0);
        check("rstmid_cdata", core_data_o, '0);
        core_done_i = 1'b0;
        core_data_i = '0;
        P_strobe_i = '0;
        @(negedge clk);
        rst_n = 1'b1;
        set_req(1, 32'h0000_6000, 1'b0, 1'b0, 5'd0);
        push_exp(1, 32'h0000_6000, 1'b0, 1'b0, 5'd0);
        wait_issue(20, n);
        check("rstmid_first_lat", n, 1);
        check("rstmid_first_id", core_id_o, 2'b10);
        serve(1, 32'h0000_6000, 32'h0000_6000, 1, 1'b0, {8{32'h7777_0000}}, 2'b10, "rstmid_txn");

        // Simultaneous requests after reset, then continuous rotation
        do_reset();
        set_req(0, 32'h0000_a000, 1'b0, 1'b0, 5'd0);
        set_req(1, 32'h0000_b000, 1'b1, 1'b0, 5'd0);
        push_exp(0, 32'h0000_a000, 1'b0, 1'b0, 5'd0);
        push_exp(1, 32'h0000_b000, 1'b1, 1'b0, 5'd0);
        wait_issue(20, n);
        t0 = cyc;
        serve(0, 32'h0000_a000, 32'h0000_a000, 3, 1'b0, {8{32'h0a0a_0a0a}}, 2'b01, "sim0");
        wait_issue(20, n);
        t1 = cyc;
        check("sim_issue_gap", t1 - t0, 6);
        serve(1, 32'h0000_b000, 32'h0000_b000, 3, 1'b0, {8{32'h0b0b_0b0b}}, 2'b10, "sim1");

        set_req(0, 32'h0000_c000, 1'b0, 1'b0, 5'd0);
        set_req(1, 32'h0000_d000, 1'b0, 1'b0, 5'd0);
        for (int i = 0; i < 4; i++) begin
            push_exp(i % 2, (i % 2 == 0) ? 32'h0000_c000 : 32'h0000_d000, 1'b0, 1'b0, 5'd0);
        end
        for (int i = 0; i < 4; i++) begin
            wait_issue(20, n);
            serve(i % 2, (i % 2 == 0) ? 32'h0000_c000 : 32'h0000_d000,
                  (i % 2 == 0) ? 32'h0000_c000 : 32'h0000_d000, 1, 1'b0,
                  {8{32'h1234_0000 + i}}, N'(1) << (i % 2), $sformatf("rot%0d", i));
            set_req(i % 2, (i % 2 == 0) ? 32'h0000_c000 : 32'h0000_d000, 1'b0, 1'b0, 5'd0);
        end
        P_strobe_i = '0;
        repeat (3) @(negedge clk);

        // Spurious done while idle
        core_done_i = 1'b1;
        core_data_i = {8{32'h5a5a_5a5a}};
        #1;
        check("spur_done", P_done_o, '0);
        @(negedge clk);
        core_done_i = 1'b0;
        check("spur_id", core_id_o, '0);
        check("spur_strobe", core_strobe_o, 1'b0);
        @(negedge clk);
        check("spur_strobe2", core_strobe_o, 1'b0);

`ifdef ARB_LR_LOCK_EN
        do_reset();
        set_req(1, 32'h0000_e000, 1'b0, 1'b0, 5'd0);
        set_req(0, 32'h0000_f000, 1'b0, 1'b1, 5'b00010);
        push_exp(0, 32'h0000_f000, 1'b0, 1'b1, 5'b00010);
        push_exp(0, 32'h0000_f000, 1'b1, 1'b1, 5'b00011);
        push_exp(1, 32'h0000_e000, 1'b0, 1'b0, 5'd0);
        wait_issue(20, n);
        serve(0, 32'h0000_f000, 32'h0000_f000, 1, 1'b0, {8{32'h0c0c_0c0c}}, 2'b01, "lr");
        repeat (3) @(negedge clk);
        check("lock_hold_strobe", core_strobe_o, 1'b0);
        set_req(0, 32'h0000_f000, 1'b1, 1'b1, 5'b00011);
        wait_issue(20, n);
        serve(0, 32'h0000_f000, 32'h0000_f000, 1, 1'b0, {8{32'h0d0d_0d0d}}, 2'b01, "sc");
        wait_issue(20, n);
        serve(1, 32'h0000_e000, 32'h0000_e000, 1, 1'b0, {8{32'h0e0e_0e0e}}, 2'b10, "after_sc");

        do_reset();
        set_req(1, 32'h0000_e100, 1'b0, 1'b0, 5'd0);
        set_req(0, 32'h0000_f100, 1'b0, 1'b1, 5'b00010);
        push_exp(0, 32'h0000_f100, 1'b0, 1'b1, 5'b00010);
        push_exp(1, 32'h0000_e100, 1'b0, 1'b0, 5'd0);
        wait_issue(20, n);
        serve(0, 32'h0000_f100, 32'h0000_f100, 0, 1'b0, {8{32'h0f0f_0f0f}}, 2'b01, "lr_to");
        wait_issue(100, n);
        check("lock_timeout_gap_ok", (n + 2 >= LOCK_CYCLES) && (n + 2 <= LOCK_CYCLES + 2), 1'b1);
        serve(1, 32'h0000_e100, 32'h0000_e100, 1, 1'b0, {8{32'h1010_1010}}, 2'b10, "after_to");
`endif

        check("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
